tower_pack: RTL
===============

Name: tower_pack

Overview:
- Zero-suppression packer for the calorimeter tower grid; the transmit-side counterpart of the tower unpacker.
- Accumulates per-tower et/e deposits into an internal eta×phi grid.
- On a start command, scans the grid in index order and serializes every tower above threshold as an (eta, phi, et, e) record on a valid/ready stream.
- Clears the grid during the scan so the next event starts empty.

Parameters:
- ETA_W, 3, eta index width (2^ETA_W eta bins)
- PHI_W, 3, phi index width (2^PHI_W phi bins)
- ET_W, 11, transverse energy width
- E_W, 11, energy width
- ET_THRESH, 0, a tower is emitted only if et > ET_THRESH

Ports:
- clk  in  1  clock
- rst  in  1  reset
- wr_en  in  1  deposit strobe
- wr_eta  in  ETA_W  deposit eta
- wr_phi  in  PHI_W  deposit phi
- wr_et  in  ET_W  deposit et
- wr_e  in  E_W  deposit e
- start  in  1  begin scan/flush (pulse)
- busy  out  1  high in SCAN/EMIT/DONE
- out_valid  out  1  record valid
- out_ready  in  1  downstream accept
- out_eta  out  ETA_W  record eta
- out_phi  out  PHI_W  record phi
- out_et  out  ET_W  record et
- out_e  out  E_W  record e
- done  out  1  one-cycle pulse at scan end
- count  out  ETA_W+PHI_W+1  records emitted in last/current scan

Behaviour:
- Reset rst, asynchronous, active-high; clock clk. Reset clears every grid entry, state=IDLE, index=0, busy=0, out_valid=0, out_* data=0, done=0, count=0.
- Grid: N=2^(ETA_W+PHI_W) entries of {et, e}. Index = eta + phi·2^ETA_W.
- Deposits are accepted only in IDLE and ignored when busy=1.
- A deposit adds into the addressed entry: et and e each saturate independently at all-ones; there is no wrap.
- States: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - If wr_en and start arrive in the same cycle, the deposit is applied and the scan starts next cycle, so the deposit is included.
  - start → SCAN with index=0, count=0.
  - start while busy is ignored.
- SCAN: examines one entry per cycle at index i.
  - If et > ET_THRESH: load the out_* registers with (i mod 2^ETA_W, i / 2^ETA_W, et, e), set out_valid=1 next cycle, go to EMIT.
  - Otherwise, clear entry i. If i = N−1 go to DONE, else i+1.
- EMIT:
  - out_valid and out_* are held stable until out_ready is sampled high. out_ready before valid has no effect.
  - On the handshake cycle: clear entry i, count+1, out_valid=0 next cycle. If i = N−1 go to DONE, else go to SCAN at i+1.
  - Back-to-back records therefore have at least one gap cycle.
- DONE: done=1 for exactly one cycle, busy=1; next cycle goes to IDLE with busy=0. count holds until the next start.
- Latency:
  - start at cycle 0 → entry 0 examined at cycle 1.
  - Empty grid: done at cycle N+1, busy low at cycle N+2.
- out_et is always > ET_THRESH. Entries at or below threshold are cleared silently.
- Reset mid-scan aborts immediately: out_valid drops and the grid is fully cleared.

Test Plan:
- Reset, then start with no deposits → no out_valid; done pulses at cycle 65 (N=64); count=0; busy low at cycle 66.
- Deposits (eta=2,phi=1,et=100,e=120) and (eta=7,phi=7,et=5,e=6), out_ready=1, start → records (2,1,100,120) then (7,7,5,6) in that order; count=2; a second start gives count=0.
- Two deposits at (3,4) with et=1500 then et=1000 → emitted et=2047 (saturated); e sums normally.
- ET_THRESH=10; deposits et=10 at (0,0) and et=11 at (1,0) → only (1,0) is emitted; (0,0) is cleared and absent on a rescan.
- out_ready held low for 20 cycles on the first record → out_valid and data stay stable for all 20 cycles; wr_en during this time is ignored (the grid is unchanged, checked on the next scan); start during this time is ignored.
- Deposit (5,5), start, assert rst while the record is valid → outputs return to reset values at once; a following start emits nothing.

Source files
------------

// File: rtl/tower_pack.sv
`default_nettype none
// ============================================================================
//  Module   : tower_pack
//  Purpose  : Zero-suppression packer for the calorimeter tower grid.
//             Deposits accumulate (saturating) into an eta x phi grid.
//             On start, the grid is scanned in index order
//             (index = eta + phi * 2^ETA_W). Every tower with et above
//             ET_THRESH is emitted as an (eta, phi, et, e) record on a
//             valid/ready stream. The grid is cleared as the scan passes,
//             so the next event starts from an empty grid.
//  Ports    : clk, rst           - clock, asynchronous active-high reset
//             wr_en/wr_eta/wr_phi/wr_et/wr_e - deposit (accepted in idle only)
//             start              - begin scan/flush pulse (ignored while busy)
//             busy               - scan, emit or done phase in progress
//             out_valid/out_ready, out_eta/out_phi/out_et/out_e - record stream
//             done               - one-cycle pulse at the end of a scan
//             count              - records emitted in the last/current scan
//  Revision : 1.0 - initial release
// ============================================================================
module tower_pack #(
   parameter int ETA_W     = 3,
   parameter int PHI_W     = 3,
   parameter int ET_W      = 11,
   parameter int E_W       = 11,
   parameter int ET_THRESH = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [ETA_W-1:0]       wr_eta,
   input  logic [PHI_W-1:0]       wr_phi,
   input  logic [ET_W-1:0]        wr_et,
   input  logic [E_W-1:0]         wr_e,
   input  logic                   start,
   output logic                   busy,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ETA_W-1:0]       out_eta,
   output logic [PHI_W-1:0]       out_phi,
   output logic [ET_W-1:0]        out_et,
   output logic [E_W-1:0]         out_e,
   output logic                   done,
   output logic [ETA_W+PHI_W:0]   count
);

   localparam int             c_IDX_W  = ETA_W + PHI_W;
   localparam int             c_N      = 1 << c_IDX_W;
   localparam logic [ET_W-1:0] c_THRESH = ET_W'(ET_THRESH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_EMIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_IDX_W-1:0]   r_idx;
   logic [c_IDX_W-1:0]   w_idx_nxt;
   logic [c_IDX_W:0]     r_count;
   logic [c_IDX_W:0]     w_count_nxt;

   logic                 w_deposit;
   logic                 w_clear;
   logic                 w_load;

   logic [ET_W-1:0]      r_grid_et [c_N];
   logic [E_W-1:0]       r_grid_e  [c_N];

   logic [c_IDX_W-1:0]   w_wr_idx;
   logic [ET_W:0]        w_et_sum;
   logic [E_W:0]         w_e_sum;
   logic [ET_W-1:0]      w_et_sat;
   logic [E_W-1:0]       w_e_sat;

   logic [ET_W-1:0]      w_cur_et;
   logic [E_W-1:0]       w_cur_e;
   logic                 w_last;
   logic                 w_above;

   // ------------------------------------------------------------------------
   // Deposit path: phi forms the upper index bits, eta the lower bits.
   // The extra sum bit is the carry; a carry forces the field to all-ones.
   // ------------------------------------------------------------------------
   assign w_wr_idx = {wr_phi, wr_eta};
   assign w_et_sum = {1'b0, r_grid_et[w_wr_idx]} + {1'b0, wr_et};
   assign w_e_sum  = {1'b0, r_grid_e[w_wr_idx]}  + {1'b0, wr_e};
   assign w_et_sat = w_et_sum[ET_W] ? {ET_W{1'b1}} : w_et_sum[ET_W-1:0];
   assign w_e_sat  = w_e_sum[E_W]   ? {E_W{1'b1}}  : w_e_sum[E_W-1:0];

   // ------------------------------------------------------------------------
   // Scan path
   // ------------------------------------------------------------------------
   assign w_cur_et = r_grid_et[r_idx];
   assign w_cur_e  = r_grid_e[r_idx];
   assign w_last   = &r_idx;
   assign w_above  = (w_cur_et > c_THRESH);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_count_nxt = r_count;
      w_deposit   = 1'b0;
      w_clear     = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A deposit in the start cycle still lands before the scan.
            w_deposit = wr_en;
            if (start) begin
               w_state_nxt = S_SCAN;
               w_idx_nxt   = '0;
               w_count_nxt = '0;
            end
         end
         S_SCAN: begin
            if (w_above) begin
               w_load      = 1'b1;
               w_state_nxt = S_EMIT;
            end else begin
               w_clear = 1'b1;
               if (w_last) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               w_clear     = 1'b1;
               w_count_nxt = r_count + 1'b1;
               if (w_last) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_SCAN;
                  w_idx_nxt   = r_idx + 1'b1;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Control registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_count <= w_count_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Record registers: loaded when the scan hits a tower above threshold and
   // held unchanged through the whole emit phase.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_eta <= '0;
         out_phi <= '0;
         out_et  <= '0;
         out_e   <= '0;
      end else if (w_load) begin
         out_eta <= r_idx[ETA_W-1:0];
         out_phi <= r_idx[c_IDX_W-1:ETA_W];
         out_et  <= w_cur_et;
         out_e   <= w_cur_e;
      end
   end

   // ------------------------------------------------------------------------
   // Tower grid. Deposit and clear occur in different states, so they never
   // collide on the same cycle.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < c_N; k++) begin
            r_grid_et[k] <= '0;
            r_grid_e[k]  <= '0;
         end
      end else if (w_deposit) begin
         r_grid_et[w_wr_idx] <= w_et_sat;
         r_grid_e[w_wr_idx]  <= w_e_sat;
      end else if (w_clear) begin
         r_grid_et[r_idx] <= '0;
         r_grid_e[r_idx]  <= '0;
      end
   end

   // ------------------------------------------------------------------------
   // Status outputs decode straight from the state register, so an
   // asynchronous reset drops them immediately.
   // ------------------------------------------------------------------------
   assign busy      = (r_state != S_IDLE);
   assign out_valid = (r_state == S_EMIT);
   assign done      = (r_state == S_DONE);
   assign count     = r_count;

endmodule
`default_nettype wire
